awg_delay_sequencer: RTL and testbench

//  Playback scheduler for the four per-port delay RAMs loaded by the UART frame receiver.
//  On a trigger it walks each enabled port's RAM from address 1 up to that port's entry count.
//  For each entry it waits the stored 24-bit delay, then issues a one-cycle play strobe tagged with the entry index.
//  It sits between the delay RAM read ports and the waveform output stage; one independent FSM runs per port.

---
 rtl/awg_delay_sequencer.sv | 155 +++++++++++++++
 tb/tb_awg_delay_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/awg_delay_sequencer.sv
// Playback scheduler for the per-port delay RAMs: on a trigger, each enabled channel walks its
// RAM, waits each stored delay and then emits a one-cycle play strobe tagged with the entry index.
module awg_delay_sequencer #(
    parameter int NCH    = 4,
    parameter int AW     = 11,
    parameter int DW     = 24,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              I_TRIG,
    input  logic              I_ABORT,
    input  logic              I_LOOP,
    input  logic [NCH-1:0]    I_CH_EN,
    input  logic [NCH*AW-1:0] I_SEQ_LEN,
    output logic [NCH*AW-1:0] O_RD_ADDR,
    input  logic [NCH*DW-1:0] I_RD_DATA,
    output logic [NCH-1:0]    O_PLAY,
    output logic [NCH*AW-1:0] O_WAVE_ID,
    output logic [NCH-1:0]    O_BUSY,
    output logic [NCH-1:0]    O_DONE
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        FIRE  = 3'd3,
        DONE  = 3'd4
    } state_t;

    // FETCH is entered together with the address register update, so read data is
    // valid once the latency counter has counted RD_LAT cycles.
    localparam logic [1:0] LAT_DONE = 2'(RD_LAT);
    localparam logic [AW-1:0] IDX_FIRST = AW'(1);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        state_t        state;
        logic [AW-1:0] idx;
        logic [AW-1:0] len;
        logic          loop_q;
        logic [DW-1:0] cnt;
        logic [1:0]    lat;
        logic [AW-1:0] rd_addr;
        logic [AW-1:0] wave_id;
        logic          play;
        logic          busy;
        logic          done;
        logic [DW-1:0] rd_data;
        logic [AW-1:0] trig_len;

        assign rd_data  = I_RD_DATA[c*DW +: DW];
        assign trig_len = I_SEQ_LEN[c*AW +: AW];

        // A zero delay skips WAIT entirely and a delay D spends D-1..0 in WAIT, which
        // places each strobe exactly RD_LAT+2+D cycles after its reference cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state   <= IDLE;
                idx     <= '0;
                len     <= '0;
                loop_q  <= 1'b0;
                cnt     <= '0;
                lat     <= '0;
                rd_addr <= '0;
                wave_id <= '0;
                play    <= 1'b0;
                busy    <= 1'b0;
                done    <= 1'b0;
            end else begin
                play <= 1'b0;
                done <= 1'b0;
                if (I_ABORT) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (I_TRIG && I_CH_EN[c]) begin
                                len    <= trig_len;
                                loop_q <= I_LOOP;
                                idx    <= IDX_FIRST;
                                busy   <= 1'b1;
                                if (trig_len == '0) begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end else begin
                                    state   <= FETCH;
                                    rd_addr <= IDX_FIRST;
                                    lat     <= '0;
                                end
                            end
                        end
                        FETCH: begin
                            if (lat == LAT_DONE) begin
                                if (rd_data == '0) begin
                                    state   <= FIRE;
                                    play    <= 1'b1;
                                    wave_id <= idx;
                                end else begin
                                    state <= WAIT;
                                    cnt   <= rd_data - DW'(1);
                                end
                            end else begin
                                lat <= lat + 2'd1;
                            end
                        end
                        WAIT: begin
                            if (cnt == '0) begin
                                state   <= FIRE;
                                play    <= 1'b1;
                                wave_id <= idx;
                            end else begin
                                cnt <= cnt - DW'(1);
                            end
                        end
                        FIRE: begin
                            if (idx == len) begin
                                if (loop_q) begin
                                    state   <= FETCH;
                                    idx     <= IDX_FIRST;
                                    rd_addr <= IDX_FIRST;
                                    lat     <= '0;
                                end else begin
                                    state <= DONE;
                                    done  <= 1'b1;
                                end
                            end else begin
                                state   <= FETCH;
                                idx     <= idx + IDX_FIRST;
                                rd_addr <= idx + IDX_FIRST;
                                lat     <= '0;
                            end
                        end
                        DONE: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                        default: begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end

        assign O_RD_ADDR[c*AW +: AW] = rd_addr;
        assign O_WAVE_ID[c*AW +: AW] = wave_id;
        assign O_PLAY[c]             = play;
        assign O_BUSY[c]             = busy;
        assign O_DONE[c]             = done;
    end

endmodule

// File: tb/tb_awg_delay_sequencer.sv
// Directed bench for awg_delay_sequencer: a RAM model feeds two instances (RD_LAT=1 and 3)
// and a negedge monitor logs strobe/done cycles that are compared with hand-computed values.
module tb_awg_delay_sequencer;
    localparam int NCH = 4;
    localparam int AW  = 11;
    localparam int DW  = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic trig = 1'b0, trig3 = 1'b0, abort = 1'b0, loop = 1'b0;
    logic [NCH-1:0]    ch_en = '0;
    logic [NCH*AW-1:0] seq_len = '0;
    logic [NCH*AW-1:0] rd_addr, rd_addr3, wave_id, wave_id3;
    logic [NCH*DW-1:0] rd_data, rd_data3, pipe3a, pipe3b;
    logic [NCH-1:0]    play, busy, done, play3, busy3, done3;
    logic [DW-1:0]     mem [NCH][2048];

    int cyc = 0;
    int checks = 0;
    int failures = 0;
    int play_cyc [NCH][$];
    int play_id  [NCH][$];
    int done_cyc [NCH][$];
    int play3_cnt, play3_first, play3_last, done3_cnt, done3_cyc;

    awg_delay_sequencer #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .I_TRIG(trig), .I_ABORT(abort), .I_LOOP(loop),
        .I_CH_EN(ch_en), .I_SEQ_LEN(seq_len), .O_RD_ADDR(rd_addr), .I_RD_DATA(rd_data),
        .O_PLAY(play), .O_WAVE_ID(wave_id), .O_BUSY(busy), .O_DONE(done)
    );

    awg_delay_sequencer #(.NCH(NCH), .AW(AW), .DW(DW), .RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .I_TRIG(trig3), .I_ABORT(abort), .I_LOOP(loop),
        .I_CH_EN(ch_en), .I_SEQ_LEN(seq_len), .O_RD_ADDR(rd_addr3), .I_RD_DATA(rd_data3),
        .O_PLAY(play3), .O_WAVE_ID(wave_id3), .O_BUSY(busy3), .O_DONE(done3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered-read RAM model, one stage for dut and three stages for dut3
    always @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            rd_data[c*DW +: DW] <= mem[c][rd_addr[c*AW +: AW]];
            pipe3a[c*DW +: DW]  <= mem[c][rd_addr3[c*AW +: AW]];
        end
        pipe3b   <= pipe3a;
        rd_data3 <= pipe3b;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                if (play[c]) begin
                    play_cyc[c].push_back(cyc);
                    play_id[c].push_back(int'(wave_id[c*AW +: AW]));
                end
                if (done[c]) done_cyc[c].push_back(cyc);
            end
            if (play3[0]) begin
                if (play3_cnt == 0) play3_first = cyc;
                play3_last = cyc;
                play3_cnt++;
            end
            if (done3[0]) begin
                done3_cnt++;
                done3_cyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic clearLogs();
        for (int c = 0; c < NCH; c++) begin
            play_cyc[c].delete();
            play_id[c].delete();
            done_cyc[c].delete();
        end
        play3_cnt = 0; play3_first = 0; play3_last = 0; done3_cnt = 0; done3_cyc = 0;
    endtask

    task automatic setLen(input int c, input int n);
        seq_len[c*AW +: AW] = AW'(n);
    endtask

    // Drives a one-cycle trigger (optionally with abort / dut3 trigger); tcyc is the sampled cycle
    task automatic applyStimulus(input logic [NCH-1:0] en, input logic lp, input logic ab,
                                 input logic t3, output int tcyc);
        @(negedge clk);
        ch_en = en; loop = lp; abort = ab; trig = 1'b1; trig3 = t3;
        tcyc = cyc;
        @(negedge clk);
        trig = 1'b0; trig3 = 1'b0; abort = 1'b0;
    endtask

    task automatic playAt(input string tag, input int c, input int i, input int ecyc, input int eid);
        checkOutput({tag, "_cyc"}, (play_cyc[c].size() > i) ? play_cyc[c][i] : -1, ecyc);
        checkOutput({tag, "_id"},  (play_id[c].size()  > i) ? play_id[c][i]  : -1, eid);
    endtask

    initial begin
        int t, t2;
        for (int c = 0; c < NCH; c++)
            for (int a = 0; a < 2048; a++) mem[c][a] = '0;
        clearLogs();

        repeat (3) @(negedge clk);
        checkOutput("rst_busy",  int'(busy), 0);
        checkOutput("rst_play",  int'(play | done), 0);
        checkOutput("rst_addr",  int'(rd_addr != '0), 0);
        checkOutput("rst_wave",  int'(wave_id != '0), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // T1: ch0 len 3, delays {0,5,2}
        mem[0][1] = 24'd0; mem[0][2] = 24'd5; mem[0][3] = 24'd2;
        setLen(0, 3);
        clearLogs();
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, t);
        checkOutput("t1_busy_start", int'(busy[0]), 1);
        waitUntil(t + 17);
        checkOutput("t1_busy_done", int'(busy[0]), 1);
        checkOutput("t1_done_pulse", int'(done[0]), 1);
        waitUntil(t + 18);
        checkOutput("t1_busy_after", int'(busy[0]), 0);
        waitUntil(t + 25);
        checkOutput("t1_nplay", play_cyc[0].size(), 3);
        playAt("t1_p1", 0, 0, t + 3, 1);
        playAt("t1_p2", 0, 1, t + 11, 2);
        playAt("t1_p3", 0, 2, t + 16, 3);
        checkOutput("t1_ndone", done_cyc[0].size(), 1);
        checkOutput("t1_addr_hold", int'(rd_addr[AW-1:0]), 3);

        // T2: all channels, ch2 empty
        mem[1][1] = 24'd4;
        mem[3][1] = 24'd1; mem[3][2] = 24'd0; mem[3][3] = 24'd2;
        setLen(0, 2); setLen(1, 1); setLen(2, 0); setLen(3, 3);
        clearLogs();
        applyStimulus(4'b1111, 1'b0, 1'b0, 1'b0, t);
        waitUntil(t + 25);
        checkOutput("t2_ch2_done", (done_cyc[2].size() > 0) ? done_cyc[2][0] : -1, t + 1);
        checkOutput("t2_ch2_nplay", play_cyc[2].size(), 0);
        playAt("t2_ch0_p2", 0, 1, t + 11, 2);
        playAt("t2_ch1_p1", 1, 0, t + 7, 1);
        playAt("t2_ch3_p2", 3, 1, t + 7, 2);
        playAt("t2_ch3_p3", 3, 2, t + 12, 3);
        checkOutput("t2_ch3_done", (done_cyc[3].size() > 0) ? done_cyc[3][0] : -1, t + 13);

        // T3: looping len 2, delays {1,1}, then abort
        mem[0][1] = 24'd1; mem[0][2] = 24'd1;
        setLen(0, 2);
        clearLogs();
        applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, t);
        waitUntil(t + 17);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t3_busy_abort", int'(busy[0]), 0);
        waitUntil(t + 40);
        checkOutput("t3_nplay", play_cyc[0].size(), 4);
        playAt("t3_p1", 0, 0, t + 4, 1);
        playAt("t3_p3", 0, 2, t + 12, 1);
        playAt("t3_p4", 0, 3, t + 16, 2);
        checkOutput("t3_ndone", done_cyc[0].size(), 0);

        // T4: retrigger while ch0 busy, ch1 idle
        mem[0][1] = 24'd0; mem[0][2] = 24'd5; mem[0][3] = 24'd2;
        setLen(0, 3); setLen(1, 1);
        clearLogs();
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, t);
        waitUntil(t + 4);
        setLen(0, 1);
        applyStimulus(4'b0011, 1'b0, 1'b0, 1'b0, t2);
        waitUntil(t + 30);
        checkOutput("t4_t2_rel", t2 - t, 5);
        checkOutput("t4_ch0_nplay", play_cyc[0].size(), 3);
        playAt("t4_ch0_p3", 0, 2, t + 16, 3);
        checkOutput("t4_ch0_done", (done_cyc[0].size() > 0) ? done_cyc[0][0] : -1, t + 17);
        playAt("t4_ch1_p1", 1, 0, t2 + 7, 1);
        checkOutput("t4_ch1_done", (done_cyc[1].size() > 0) ? done_cyc[1][0] : -1, t2 + 8);

        // T5: trigger with abort, then async reset mid-WAIT
        setLen(0, 3);
        clearLogs();
        applyStimulus(4'b1111, 1'b0, 1'b1, 1'b0, t);
        checkOutput("t5_ab_busy", int'(busy), 0);
        waitUntil(t + 12);
        checkOutput("t5_ab_nplay", play_cyc[0].size() + play_cyc[1].size() + play_cyc[3].size(), 0);
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b0, t);
        waitUntil(t + 6);
        checkOutput("t5_busy_pre", int'(busy[0]), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", int'(busy), 0);
        checkOutput("t5_rst_addr", int'(rd_addr != '0), 0);
        checkOutput("t5_rst_wave", int'(wave_id != '0), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // T6: 2047 entries of zero delay on both latencies
        for (int a = 1; a < 2048; a++) mem[0][a] = '0;
        setLen(0, 2047);
        clearLogs();
        applyStimulus(4'b0001, 1'b0, 1'b0, 1'b1, t);
        waitUntil(t + 10300);
        checkOutput("t6_nplay", play_cyc[0].size(), 2047);
        playAt("t6_first", 0, 0, t + 3, 1);
        playAt("t6_last", 0, 2046, t + 6141, 2047);
        checkOutput("t6_ndone", done_cyc[0].size(), 1);
        checkOutput("t6_done", (done_cyc[0].size() > 0) ? done_cyc[0][0] : -1, t + 6142);
        checkOutput("t6l3_nplay", play3_cnt, 2047);
        checkOutput("t6l3_first", play3_first, t + 5);
        checkOutput("t6l3_last", play3_last, t + 10235);
        checkOutput("t6l3_last_id", int'(wave_id3[AW-1:0]), 2047);
        checkOutput("t6l3_ndone", done3_cnt, 1);
        checkOutput("t6l3_done", done3_cyc, t + 10236);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
